// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
// A burst starts only when the FIFO is not almost-full; individual beats stall on full.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]              req_last_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic                            fifo_full_i,
    input  logic                            fifo_a_full_i,
    output logic                            fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]           fifo_wr_data_o,
    output logic [NUM_REQ-1:0]              grant_o,
    output logic                            busy_o,
    output logic [$clog2(MAX_BURST+1)-1:0]  beat_cnt_o
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST+1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d, winner;
    logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
    logic              found, beat, last;

    assign busy_o       = state_q == BURST;
    assign grant_o      = grant_q;
    assign beat_cnt_o   = beat_cnt_q;
    assign req_ready_o  = (busy_o && !fifo_full_i) ? grant_q : '0;
    assign beat         = |(req_valid_i & req_ready_o);
    assign last         = |(req_last_i & grant_q);
    assign fifo_wr_en_o = beat;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin : search
        int j;
        found  = 1'b0;
        winner = '0;
        j      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req_valid_i[IW'(j)]) begin
                found  = 1'b1;
                winner = IW'(j);
            end
        end
    end

    // grant_q is zero in IDLE, so the mux naturally yields 0 there
    always_comb begin : data_mux
        fifo_wr_data_o = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (grant_q[k]) fifo_wr_data_o = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin : next_state
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        if (state_q == IDLE) begin
            if (found && !fifo_a_full_i) begin
                state_d    = BURST;
                grant_d    = NUM_REQ'(1) << winner;
                rr_ptr_d   = (winner == IW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
                beat_cnt_d = '0;
            end
        end else if (beat) begin
            if (last || beat_cnt_q == CW'(MAX_BURST-1)) begin
                state_d    = IDLE;
                grant_d    = '0;
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: requester queues feed the arbiter; expected FIFO writes
// ({grant, data}) are queued up front and matched by an independent monitor.
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_last_i;
    logic [3:0]  req_ready_o;
    logic        fifo_full_i;
    logic        fifo_a_full_i;
    logic        fifo_wr_en_o;
    logic [7:0]  fifo_wr_data_o;
    logic [3:0]  grant_o;
    logic        busy_o;
    logic [2:0]  beat_cnt_o;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
        .req_ready_o(req_ready_o),
        .fifo_full_i(fifo_full_i), .fifo_a_full_i(fifo_a_full_i),
        .fifo_wr_en_o(fifo_wr_en_o), .fifo_wr_data_o(fifo_wr_data_o),
        .grant_o(grant_o), .busy_o(busy_o), .beat_cnt_o(beat_cnt_o)
    );

    always #5 clk = ~clk;

    logic [8:0]  src_q [4][$];
    logic [11:0] exp_q [$];
    int          errors = 0;
    int          checks = 0;
    int          n_wr = 0;
    int          n0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic src(input int k, input logic [7:0] d, input logic l);
        src_q[k].push_back({l, d});
    endtask

    task automatic send(input int k, input logic [7:0] d, input logic l);
        src(k, d, l);
        exp_q.push_back({4'(1 << k), d});
    endtask

    function automatic bit all_idle();
        return !busy_o && exp_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0
               && src_q[2].size() == 0 && src_q[3].size() == 0;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        while (!all_idle() && n < 200) begin
            step(1);
            n++;
        end
        chk(name, 32'(all_idle()), 32'd1);
    endtask

    // Requester model: present queue heads at negedge, pop what was accepted at the edge
    initial begin
        logic [3:0] fire;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                req_valid_i[k]       = src_q[k].size() > 0;
                req_data_i[k*8 +: 8] = src_q[k].size() > 0 ? src_q[k][0][7:0] : 8'h00;
                req_last_i[k]        = src_q[k].size() > 0 ? src_q[k][0][8] : 1'b0;
            end
            #1 fire = req_valid_i & req_ready_o;
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++)
                if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        end
    end

    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (fifo_wr_en_o) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got grant=%b data=%h, expected no write at %0t",
                             grant_o, fifo_wr_data_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("write", {20'd0, grant_o, fifo_wr_data_o}, {20'd0, e});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        fifo_full_i = 1'b0;
        fifo_a_full_i = 1'b0;
        step(2);
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_cnt", 32'(beat_cnt_o), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        rst = 1'b0;
        step(1);

        // All four valid, no last: 0,1,2,3,0,1,2,3 in 4-beat bursts with one idle cycle each
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 8; i++) src(k, 8'(k*16 + i), 1'b0);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++)
                for (int i = 0; i < 4; i++) exp_q.push_back({4'(1 << k), 8'(k*16 + r*4 + i)});
        n0 = n_wr;
        step(1);
        chk("rr_first_grant", 32'(grant_o), 32'b0001);
        step(38);
        chk("rr_busy_before_end", 32'(busy_o), 32'd1);
        step(1);
        chk("rr_busy_at_end", 32'(busy_o), 32'd0);
        chk("rr_write_count", 32'(n_wr - n0), 32'd32);
        wait_idle("rr_idle");

        // Single burst terminated by last
        send(0, 8'h11, 1'b0);
        send(0, 8'h22, 1'b0);
        send(0, 8'h33, 1'b1);
        step(1);
        chk("single_grant", 32'(grant_o), 32'b0001);
        chk("single_cnt0", 32'(beat_cnt_o), 32'd0);
        chk("single_wr_en", 32'(fifo_wr_en_o), 32'd1);
        step(1);
        chk("single_cnt1", 32'(beat_cnt_o), 32'd1);
        step(1);
        chk("single_cnt2", 32'(beat_cnt_o), 32'd2);
        step(1);
        chk("single_busy_end", 32'(busy_o), 32'd0);
        chk("single_grant_end", 32'(grant_o), 32'd0);
        chk("single_cnt_end", 32'(beat_cnt_o), 32'd0);
        wait_idle("single_idle");

        // rr_ptr=1 now: req3 must win over req0
        src(0, 8'h50, 1'b0);
        src(0, 8'h51, 1'b1);
        src(3, 8'h53, 1'b0);
        src(3, 8'h54, 1'b1);
        exp_q.push_back({4'b1000, 8'h53});
        exp_q.push_back({4'b1000, 8'h54});
        exp_q.push_back({4'b0001, 8'h50});
        exp_q.push_back({4'b0001, 8'h51});
        step(1);
        chk("skip_grant", 32'(grant_o), 32'b1000);
        wait_idle("skip_idle");

        // Almost-full blocks burst start
        fifo_a_full_i = 1'b1;
        send(1, 8'h61, 1'b0);
        send(1, 8'h62, 1'b1);
        n0 = n_wr;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("afull_grant", 32'(grant_o), 32'd0);
            chk("afull_busy", 32'(busy_o), 32'd0);
        end
        chk("afull_no_write", 32'(n_wr - n0), 32'd0);
        fifo_a_full_i = 1'b0;
        step(1);
        chk("afull_release_grant", 32'(grant_o), 32'b0010);
        wait_idle("afull_idle");

        // Full stalls req2 for two cycles after its second beat
        for (int i = 0; i < 4; i++) send(2, 8'hA0 + 8'(i), 1'b0);
        step(1);
        chk("full_grant", 32'(grant_o), 32'b0100);
        step(2);
        chk("full_cnt_before", 32'(beat_cnt_o), 32'd2);
        fifo_full_i = 1'b1;
        #1;
        chk("full_ready", 32'(req_ready_o), 32'd0);
        chk("full_wr_en", 32'(fifo_wr_en_o), 32'd0);
        step(1);
        chk("full_cnt_hold1", 32'(beat_cnt_o), 32'd2);
        step(1);
        chk("full_cnt_hold2", 32'(beat_cnt_o), 32'd2);
        chk("full_busy_hold", 32'(busy_o), 32'd1);
        fifo_full_i = 1'b0;
        #1;
        chk("full_ready_resume", 32'(req_ready_o), 32'b0100);
        step(1);
        chk("full_cnt3", 32'(beat_cnt_o), 32'd3);
        step(1);
        chk("full_busy_end", 32'(busy_o), 32'd0);
        wait_idle("full_idle");

        // Async reset during a req1 burst; only the first beat may reach the FIFO
        src(1, 8'h71, 1'b0);
        src(1, 8'h72, 1'b0);
        src(1, 8'h73, 1'b0);
        src(1, 8'h74, 1'b1);
        exp_q.push_back({4'b0010, 8'h71});
        step(1);
        chk("arst_grant", 32'(grant_o), 32'b0010);
        step(1);
        chk("arst_cnt", 32'(beat_cnt_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_grant_clr", 32'(grant_o), 32'd0);
        chk("arst_busy_clr", 32'(busy_o), 32'd0);
        chk("arst_wr_en_clr", 32'(fifo_wr_en_o), 32'd0);
        chk("arst_ready_clr", 32'(req_ready_o), 32'd0);
        chk("arst_cnt_clr", 32'(beat_cnt_o), 32'd0);
        src_q[1].delete();
        step(2);
        rst = 1'b0;
        // rr_ptr back at 0: req0 wins before req3
        send(0, 8'h80, 1'b1);
        send(3, 8'h83, 1'b1);
        step(1);
        chk("arst_rr_grant", 32'(grant_o), 32'b0001);
        wait_idle("arst_idle");

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
